write_data_streamer: RTL and testbench
======================================

WRITE_DATA_STREAMER -- requirements
Module: write_data_streamer

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3, meaning the number of retries accepted per transfer before it is aborted.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port write_request  input  1  requester holds it high until acked.
REQ-005 SHALL have port write_data  input  128  payload [0:127]; sampled on the ack cycle.
REQ-006 SHALL have port write_request_ack  output  1  accept strobe for write_request.
REQ-007 SHALL have port write_request_ack_tag  output  4  tag assigned to the accepted transfer.
REQ-008 SHALL have port data_stall  input  1  downstream back-pressure; suppresses the current beat.
REQ-009 SHALL have port retry  input  1  downstream request to resend a transfer.
REQ-010 SHALL have port retry_tag  input  4  tag that retry refers to.
REQ-011 SHALL have port data_valid  output  1  beat strobe.
REQ-012 SHALL have port data_valid_tag  output  4  tag of the current beat.
REQ-013 SHALL have port data  output  8  beat payload.
REQ-014 SHALL have port last_data_valid  output  1  marks beat 15.
REQ-015 SHALL have port busy  output  1  transfer in progress (state != IDLE).
REQ-016 SHALL have port abort  output  1  one-cycle pulse when retry limit is exceeded.

Function
REQ-017 SHALL implement states IDLE, BEAT, POST; one transfer outstanding at a time.
REQ-018 SHALL drive write_request_ack = write_request && state==IDLE (same cycle), with write_request_ack_tag = tag counter.
REQ-019 On an ack edge SHALL capture write_data and the tag, clear beat index and retry count, and enter BEAT.
REQ-020 Tag counter SHALL increment modulo 16 on each ack; 4'hF wraps to 4'h0.
REQ-021 In BEAT, data_valid SHALL equal !data_stall; data SHALL be buffer[i*8 +: 8] (byte 0 = bits 0..7, the MSB end); data_valid_tag SHALL be the captured tag.
REQ-022 Beat index i SHALL advance by 1 only on a cycle with data_valid=1 and no matching retry; while stalled, i holds.
REQ-023 last_data_valid SHALL be high only with data_valid on i=15; that beat SHALL move the state to POST.
REQ-024 POST SHALL last exactly one cycle, then go to IDLE unless a matching retry is seen; no ack is given in POST.
REQ-025 A matching retry (retry && retry_tag==captured tag, state BEAT or POST) SHALL set i=0 and stay in or return to BEAT next cycle, incrementing retry count.
REQ-026 A retry coinciding with a beat SHALL leave that beat presented unchanged; beat 0 follows on the next cycle.
REQ-027 A matching retry arriving when retry count == MAX_RETRY SHALL pulse abort for one cycle and return to IDLE.
REQ-028 Retries with a non-matching tag, or arriving in IDLE, SHALL be ignored.
REQ-029 Outside BEAT, data_valid and last_data_valid SHALL be 0 and data SHALL be 8'h00.

Reset
REQ-030 reset_n low SHALL asynchronously force state IDLE, tag counter 0, i 0, retry count 0, buffer 0, and every output 0.
REQ-031 Reset asserted during a transfer SHALL abandon it without an abort pulse; the first transfer after reset SHALL get tag 0.

Verification
REQ-032 After reset, write_request with data 128'h00112233445566778899AABBCCDDEEFF -> same-cycle ack, tag 0; beats 00,11,...,FF on the next 16 cycles; last on FF; busy low 2 cycles after the last beat.
REQ-033 data_stall high for 3 cycles while i=5 -> no data_valid in those cycles; beat 5 (8'h55) follows; the transfer spans 19 beat-phase cycles.
REQ-034 Matching retry on beat 7, and separately in the POST cycle -> beat still shown; beat 0 (8'h00) on the next cycle; full 16 beats resent.
REQ-035 Retry with retry_tag != current tag during beats -> ignored; the beat sequence is unchanged.
REQ-036 MAX_RETRY=3, 4 matching retries -> 4th gives an abort pulse and IDLE; the next request is acked with tag 1.
REQ-037 17 back-to-back transfers -> tags 0..15 then 0; reset_n low on beat 9 -> all outputs 0 immediately and no abort pulse.

Source files
------------

// File: rtl/write_data_streamer.sv
// Accepts one 128-bit write at a time and streams it as sixteen byte beats.
// Downstream may stall beats or request a tagged resend, up to MAX_RETRY times.
module write_data_streamer #(
    parameter int MAX_RETRY = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         write_request,
    input  logic [0:127] write_data,
    output logic         write_request_ack,
    output logic [3:0]   write_request_ack_tag,
    input  logic         data_stall,
    input  logic         retry,
    input  logic [3:0]   retry_tag,
    output logic         data_valid,
    output logic [3:0]   data_valid_tag,
    output logic [7:0]   data,
    output logic         last_data_valid,
    output logic         busy,
    output logic         abort
);

    localparam int RCW = $clog2(MAX_RETRY + 2);

    typedef enum logic [1:0] {IDLE, BEAT, POST} state_t;

    state_t         state, state_nxt;
    logic [3:0]     tag_cnt, tag_cnt_nxt;
    logic [3:0]     cur_tag, cur_tag_nxt;
    logic [3:0]     beat_idx, beat_idx_nxt;
    logic [RCW-1:0] retry_cnt, retry_cnt_nxt;
    logic [0:127]   buffer, buffer_nxt;
    logic           retry_hit;
    logic           retry_exhausted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tag_cnt   <= '0;
            cur_tag   <= '0;
            beat_idx  <= '0;
            retry_cnt <= '0;
            buffer    <= '0;
        end else begin
            state     <= state_nxt;
            tag_cnt   <= tag_cnt_nxt;
            cur_tag   <= cur_tag_nxt;
            beat_idx  <= beat_idx_nxt;
            retry_cnt <= retry_cnt_nxt;
            buffer    <= buffer_nxt;
        end
    end

    always_comb begin
        state_nxt             = state;
        tag_cnt_nxt           = tag_cnt;
        cur_tag_nxt           = cur_tag;
        beat_idx_nxt          = beat_idx;
        retry_cnt_nxt         = retry_cnt;
        buffer_nxt            = buffer;
        write_request_ack     = 1'b0;
        write_request_ack_tag = tag_cnt;
        data_valid            = 1'b0;
        data_valid_tag        = '0;
        data                  = '0;
        last_data_valid       = 1'b0;
        busy                  = (state != IDLE);

        retry_hit       = retry && (retry_tag == cur_tag) && (state != IDLE);
        retry_exhausted = retry_hit && (retry_cnt == RCW'(MAX_RETRY));
        abort           = retry_exhausted;

        case (state)
            IDLE: begin
                // ack is combinational on the request, so hold it off while reset is low
                if (write_request && reset_n) begin
                    write_request_ack = 1'b1;
                    buffer_nxt        = write_data;
                    cur_tag_nxt       = tag_cnt;
                    tag_cnt_nxt       = tag_cnt + 4'd1;
                    beat_idx_nxt      = '0;
                    retry_cnt_nxt     = '0;
                    state_nxt         = BEAT;
                end
            end
            BEAT: begin
                data_valid      = !data_stall;
                data_valid_tag  = cur_tag;
                data            = buffer[{beat_idx, 3'b000} +: 8];
                last_data_valid = !data_stall && (beat_idx == 4'd15);
                if (!data_stall) begin
                    if (beat_idx == 4'd15) begin
                        beat_idx_nxt = '0;
                        state_nxt    = POST;
                    end else begin
                        beat_idx_nxt = beat_idx + 4'd1;
                    end
                end
            end
            POST: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // a matching retry overrides any beat advance decided above
        if (retry_hit) begin
            if (retry_exhausted) begin
                state_nxt    = IDLE;
                beat_idx_nxt = '0;
            end else begin
                state_nxt     = BEAT;
                beat_idx_nxt  = '0;
                retry_cnt_nxt = retry_cnt + RCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_write_data_streamer.sv
// Randomized scoreboard bench for write_data_streamer: a transfer-level model
// queues expected beats, a negedge monitor pops and compares them.
module tb_write_data_streamer;

    localparam int MAX_RETRY = 3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         write_request;
    logic [127:0] write_data;
    logic         write_request_ack;
    logic [3:0]   write_request_ack_tag;
    logic         data_stall;
    logic         retry;
    logic [3:0]   retry_tag;
    logic         data_valid;
    logic [3:0]   data_valid_tag;
    logic [7:0]   data;
    logic         last_data_valid;
    logic         busy;
    logic         abort;

    always #5 clk = ~clk;

    write_data_streamer #(.MAX_RETRY(MAX_RETRY)) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .write_request         (write_request),
        .write_data            (write_data),
        .write_request_ack     (write_request_ack),
        .write_request_ack_tag (write_request_ack_tag),
        .data_stall            (data_stall),
        .retry                 (retry),
        .retry_tag             (retry_tag),
        .data_valid            (data_valid),
        .data_valid_tag        (data_valid_tag),
        .data                  (data),
        .last_data_valid       (last_data_valid),
        .busy                  (busy),
        .abort                 (abort)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_abort_obs = 0;
    logic [12:0] exp_q[$];
    logic [12:0] mon_exp;
    logic obs_last;

    // Reference model: phase 0 = no transfer, 1 = streaming beats, 2 = post beat
    int           m_phase;
    int           m_pos;
    int           m_retries;
    logic [3:0]   m_tag;
    logic [3:0]   m_cur;
    logic [127:0] m_pay;

    function automatic logic [7:0] byte_of(input logic [127:0] p, input int k);
        logic [127:0] s;
        s = p >> (8 * (15 - k));
        return s[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL beat_unexpected: got tag %0h data %02h, expected no beat", data_valid_tag, data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("beat", {19'd0, data_valid_tag, data, last_data_valid}, {19'd0, mon_exp});
            end
        end
    end

    task automatic step(input logic req, input logic [127:0] wd, input logic st,
                        input logic rt, input logic [3:0] rtg);
        logic hit, e_ack, e_dv, e_abort, e_busy;
        @(posedge clk);
        #1;
        write_request = req;
        write_data    = wd;
        data_stall    = st;
        retry         = rt;
        retry_tag     = rtg;
        hit     = rt && (rtg == m_cur) && (m_phase != 0);
        e_ack   = req && (m_phase == 0);
        e_dv    = (m_phase == 1) && !st;
        e_abort = hit && (m_retries == MAX_RETRY);
        e_busy  = (m_phase != 0);
        if (e_dv)
            exp_q.push_back({m_cur, byte_of(m_pay, m_pos), (m_pos == 15) ? 1'b1 : 1'b0});
        @(negedge clk);
        check("ack", {31'd0, write_request_ack}, {31'd0, e_ack});
        if (e_ack) check("ack_tag", {28'd0, write_request_ack_tag}, {28'd0, m_tag});
        check("busy", {31'd0, busy}, {31'd0, e_busy});
        check("abort", {31'd0, abort}, {31'd0, e_abort});
        check("data_valid", {31'd0, data_valid}, {31'd0, e_dv});
        if (m_phase != 1) begin
            check("idle_data", {24'd0, data}, 32'd0);
            check("idle_last", {31'd0, last_data_valid}, 32'd0);
        end
        obs_last = last_data_valid;
        if (abort) n_abort_obs++;

        if (m_phase == 0) begin
            if (req) begin
                m_cur     = m_tag;
                m_tag     = m_tag + 4'd1;
                m_pay     = wd;
                m_pos     = 0;
                m_retries = 0;
                m_phase   = 1;
            end
        end else if (hit) begin
            if (m_retries == MAX_RETRY) begin
                m_phase = 0;
            end else begin
                m_retries++;
                m_pos   = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!st) begin
                if (m_pos == 15) m_phase = 2;
                else m_pos++;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n       = 1'b0;
        write_request = 1'b1;
        retry         = 1'b1;
        data_stall    = 1'b0;
        #1;
        check("reset_outputs_now",
              {8'd0, write_request_ack, write_request_ack_tag, data_valid, data_valid_tag,
               data, last_data_valid, busy, abort}, 32'd0);
        check("queue_at_reset", exp_q.size(), 32'd0);
        exp_q.delete();
        m_phase = 0; m_pos = 0; m_retries = 0; m_tag = '0; m_cur = '0; m_pay = '0;
        @(negedge clk);
        check("reset_outputs_held",
              {8'd0, write_request_ack, write_request_ack_tag, data_valid, data_valid_tag,
               data, last_data_valid, busy, abort}, 32'd0);
        @(posedge clk);
        #1;
        reset_n       = 1'b1;
        write_request = 1'b0;
        retry         = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // mode: 0 plain, 1 stall x3 at beat 5, 2 retry at beat 7 and in POST,
    // 3 non-matching retries, 4 retry until abort, 5 random, 6 reset at beat 9
    task automatic transfer(input logic [127:0] pl, input int mode, input int exp_span);
        int cyc, last_at, stalls, aborts0;
        logic st, rt, req;
        logic [3:0] rtg;
        aborts0 = n_abort_obs;
        step(1'b1, pl, 1'b0, 1'b0, 4'd0);
        cyc = 0; last_at = -1; stalls = 0;
        while (m_phase != 0 && cyc < 400) begin
            cyc++;
            st = 1'b0; rt = 1'b0; req = 1'b0; rtg = 4'($urandom());
            case (mode)
                1: if (m_phase == 1 && m_pos == 5 && stalls < 3) begin st = 1'b1; stalls++; end
                2: if (m_phase == 1 && m_pos == 7 && m_retries == 0) begin rt = 1'b1; rtg = m_cur; end
                   else if (m_phase == 2 && m_retries == 1) begin rt = 1'b1; rtg = m_cur; end
                3: begin rt = 1'b1; rtg = m_cur ^ 4'($urandom_range(1, 15)); end
                4: if (m_phase == 1 && m_pos == 3) begin rt = 1'b1; rtg = m_cur; end
                5: begin
                    st  = ($urandom() % 4) == 0;
                    rt  = ($urandom() % 12) == 0;
                    rtg = ($urandom() % 2) ? m_cur : 4'($urandom());
                    req = ($urandom() % 4) == 0;
                end
                6: if (m_phase == 1 && m_pos == 9) begin do_reset(); break; end
                default: ;
            endcase
            step(req, rnd128(), st, rt, rtg);
            if (obs_last && last_at < 0) last_at = cyc;
        end
        if (cyc >= 400) check("transfer_timeout", 32'(cyc), 32'd0);
        if (exp_span > 0) check("beat_span", 32'(last_at), 32'(exp_span));
        if (mode == 4) check("abort_pulses", 32'(n_abort_obs - aborts0), 32'd1);
        if (mode == 6) check("abort_on_reset", 32'(n_abort_obs - aborts0), 32'd0);
        #1;
        check("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; write_request = 1'b0; write_data = '0;
        data_stall = 1'b0; retry = 1'b0; retry_tag = '0; obs_last = 1'b0;
        m_phase = 0; m_pos = 0; m_retries = 0; m_tag = '0; m_cur = '0; m_pay = '0;
        do_reset();

        transfer(128'h00112233445566778899AABBCCDDEEFF, 0, 16);
        step(1'b0, rnd128(), 1'b0, 1'b0, 4'd0);
        transfer(rnd128(), 1, 19);
        transfer(rnd128(), 2, 0);
        transfer(rnd128(), 3, 16);

        do_reset();
        transfer(rnd128(), 4, 0);
        transfer(rnd128(), 0, 16);
        for (int i = 0; i < 5; i++)
            step(1'b0, rnd128(), 1'($urandom()), 1'b1, 4'($urandom()));

        do_reset();
        for (int i = 0; i < 17; i++) transfer(rnd128(), 0, 16);
        transfer(rnd128(), 6, 0);
        transfer(rnd128(), 0, 16);

        for (int i = 0; i < 12; i++) begin
            transfer(rnd128(), 5, 0);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                step(1'b0, rnd128(), 1'($urandom()), 1'($urandom()), 4'($urandom()));
        end

        #1;
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
